// File: rtl/mem_stage_pkg.sv
// Shared widths, encodings and bus payload types for the MEM pipeline stage.
package mem_stage_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned LD_OP_W    = 3;
    localparam int unsigned STALL_W    = 6;
    localparam int unsigned STALL_MEM  = 3;
    localparam int unsigned STALL_WB   = 4;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [LD_OP_W-1:0] LD_OP_LW  = 3'b000;
    localparam logic [LD_OP_W-1:0] LD_OP_LB  = 3'b001;
    localparam logic [LD_OP_W-1:0] LD_OP_LBU = 3'b010;
    localparam logic [LD_OP_W-1:0] LD_OP_LH  = 3'b011;
    localparam logic [LD_OP_W-1:0] LD_OP_LHU = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic                  ld_en;
        logic [LD_OP_W-1:0]    ld_op;
        logic                  rf_we;
        logic [REG_ADDR_W-1:0] rf_waddr;
        logic [XLEN-1:0]       ex_result;
    } ex_to_mem_t;

    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic                  rf_we;
        logic [REG_ADDR_W-1:0] rf_waddr;
        logic [XLEN-1:0]       rf_wdata;
    } mem_to_wb_t;

    typedef struct packed {
        logic                  rf_we;
        logic [REG_ADDR_W-1:0] rf_waddr;
        logic [XLEN-1:0]       rf_wdata;
    } mem_to_rf_t;

endpackage

// File: rtl/mem_stage_if.sv
// Bus bundle between the MEM stage and its neighbours (EX, WB, decode, data SRAM, stall control).
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic [STALL_W-1:0] stall;
    ex_to_mem_t         ex_to_mem_bus;
    logic [XLEN-1:0]    data_sram_rdata;
    logic               data_sram_rvalid;
    mem_to_wb_t         mem_to_wb_bus;
    mem_to_rf_t         mem_to_rf_bus;
    logic               stallreq_mem;

    modport master (
        output stall, ex_to_mem_bus, data_sram_rdata, data_sram_rvalid,
        input  mem_to_wb_bus, mem_to_rf_bus, stallreq_mem
    );

    modport slave (
        input  stall, ex_to_mem_bus, data_sram_rdata, data_sram_rvalid,
        output mem_to_wb_bus, mem_to_rf_bus, stallreq_mem
    );

endinterface

// File: rtl/mem_stage_load_align.sv
// Selects the addressed byte/halfword of a load word and sign/zero-extends it.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [LD_OP_W-1:0] ld_op,
    input  logic [1:0]         addr,
    input  logic [XLEN-1:0]    word,
    output logic [XLEN-1:0]    data_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        half_sel = word[15:0];
        case (addr)
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            2'd3:    byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        // Halfword lane from addr[1]; addr[0] is deliberately ignored.
        if (addr[1]) begin
            half_sel = word[31:16];
        end

        data_c = word;
        case (ld_op)
            LD_OP_LB:  data_c = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            LD_OP_LBU: data_c = {{(XLEN-8){1'b0}}, byte_sel};
            LD_OP_LH:  data_c = {{(XLEN-16){half_sel[15]}}, half_sel};
            LD_OP_LHU: data_c = {{(XLEN-16){1'b0}}, half_sel};
            default:   data_c = word;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX->MEM register, load-response FSM, load alignment and WB/forward buses.
// Optional decode bypass bus enabled by defining MEM_FWD_EN.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    mem_stage_if.slave bus
);

    ex_to_mem_t      reg_q;
    mem_state_e      state_q;
    logic [XLEN-1:0] hold_q;

    logic            mem_hold;
    logic            wb_hold;
    logic            reg_moves;
    logic            in_hold;
    logic            stallreq_c;
    logic            rf_we_c;
    logic [XLEN-1:0] word_c;
    logic [XLEN-1:0] aligned_c;
    logic [XLEN-1:0] rf_wdata_c;
    logic            unused_stall;

    assign mem_hold     = (bus.stall[STALL_MEM] == STOP);
    assign wb_hold      = (bus.stall[STALL_WB] == STOP);
    assign reg_moves    = !mem_hold || !wb_hold;
    assign unused_stall = ^{bus.stall[5], bus.stall[2:0]};

    // EX->MEM register: bubble when MEM stops but WB runs, capture when MEM runs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_q <= '0;
        end else if (mem_hold && !wb_hold) begin
            reg_q <= '0;
        end else if (!mem_hold) begin
            reg_q <= bus.ex_to_mem_bus;
        end
    end

    // Load-response FSM; read data is parked in hold_q when it arrives while MEM is stopped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_WAIT: begin
                    if (!reg_q.ld_en) begin
                        state_q <= ST_IDLE;
                    end else if (!bus.data_sram_rvalid) begin
                        state_q <= ST_WAIT;
                    end else if (mem_hold) begin
                        state_q <= ST_HOLD;
                        hold_q  <= bus.data_sram_rdata;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (reg_moves) begin
                        state_q <= ST_IDLE;
                        hold_q  <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    hold_q  <= '0;
                end
            endcase
        end
    end

    assign in_hold = (state_q == ST_HOLD);
    assign word_c  = in_hold ? hold_q : bus.data_sram_rdata;

    mem_stage_load_align u_align (
        .ld_op  (reg_q.ld_op),
        .addr   (reg_q.ex_result[1:0]),
        .word   (word_c),
        .data_c (aligned_c)
    );

    always_comb begin
        stallreq_c = reg_q.ld_en && !in_hold && !bus.data_sram_rvalid;
        rf_we_c    = reg_q.rf_we && !stallreq_c;
        rf_wdata_c = reg_q.ld_en ? aligned_c : reg_q.ex_result;
    end

    assign bus.stallreq_mem  = stallreq_c;
    assign bus.mem_to_wb_bus = '{pc:       reg_q.pc,
                                 rf_we:    rf_we_c,
                                 rf_waddr: reg_q.rf_waddr,
                                 rf_wdata: rf_wdata_c};

`ifdef MEM_FWD_EN
    assign bus.mem_to_rf_bus = '{rf_we:    rf_we_c,
                                 rf_waddr: reg_q.rf_waddr,
                                 rf_wdata: rf_wdata_c};
`else
    assign bus.mem_to_rf_bus = '0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (works with or without MEM_FWD_EN).
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam logic [5:0] S_RUN    = 6'b000000;
    localparam logic [5:0] S_HOLD   = 6'b011000;
    localparam logic [5:0] S_BUBBLE = 6'b001000;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_stage_if bus ();

    mem_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ex_to_mem_t mk_ex(input logic [31:0] pc, input logic ld_en,
                                         input logic [2:0] ld_op, input logic rf_we,
                                         input logic [4:0] waddr, input logic [31:0] res);
        ex_to_mem_t e;
        e.pc        = pc;
        e.ld_en     = ld_en;
        e.ld_op     = ld_op;
        e.rf_we     = rf_we;
        e.rf_waddr  = waddr;
        e.ex_result = res;
        return e;
    endfunction

    task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] pc, input logic we,
                             input logic [4:0] waddr, input logic [31:0] wdata, input logic sreq);
        mem_to_wb_t exp_wb;
        mem_to_rf_t exp_rf;
        exp_wb.pc       = pc;
        exp_wb.rf_we    = we;
        exp_wb.rf_waddr = waddr;
        exp_wb.rf_wdata = wdata;
`ifdef MEM_FWD_EN
        exp_rf.rf_we    = we;
        exp_rf.rf_waddr = waddr;
        exp_rf.rf_wdata = wdata;
`else
        exp_rf = '0;
`endif
        check({tag, "_wb"}, 70'(bus.mem_to_wb_bus), 70'(exp_wb));
        check({tag, "_rf"}, 70'(bus.mem_to_rf_bus), 70'(exp_rf));
        check({tag, "_sreq"}, 70'(bus.stallreq_mem), 70'(sreq));
    endtask

    task automatic check_stalled(input string tag);
        check({tag, "_sreq"}, 70'(bus.stallreq_mem), 70'(1'b1));
        check({tag, "_we"}, 70'(bus.mem_to_wb_bus.rf_we), 70'(1'b0));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.stall            = S_RUN;
        bus.ex_to_mem_bus    = '0;
        bus.data_sram_rdata  = '0;
        bus.data_sram_rvalid = 1'b0;

        #3;
        check_out("reset", 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        tick;
        tick;
        rst = 1'b1;

        // Non-load passes ex_result straight through
        bus.ex_to_mem_bus = mk_ex(32'h100, 1'b0, LD_OP_LW, 1'b1, 5'd5, 32'hDEADBEEF);
        tick;
        check_out("alu", 32'h100, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);

        // LB lane 3, sign-extended, rvalid in same cycle
        bus.ex_to_mem_bus = mk_ex(32'h104, 1'b1, LD_OP_LB, 1'b1, 5'd6, 32'h00001003);
        tick;
        check_stalled("lb_pre");
        bus.data_sram_rdata  = 32'h80FF1234;
        bus.data_sram_rvalid = 1'b1;
        #1;
        check_out("lb", 32'h104, 1'b1, 5'd6, 32'hFFFFFF80, 1'b0);

        bus.ex_to_mem_bus = mk_ex(32'h108, 1'b1, LD_OP_LHU, 1'b1, 5'd7, 32'h00002002);
        tick;
        bus.data_sram_rdata = 32'hBEEF0001;
        #1;
        check_out("lhu", 32'h108, 1'b1, 5'd7, 32'h0000BEEF, 1'b0);

        bus.ex_to_mem_bus = mk_ex(32'h10C, 1'b1, LD_OP_LH, 1'b1, 5'd8, 32'h00002002);
        tick;
        #1;
        check_out("lh", 32'h10C, 1'b1, 5'd8, 32'hFFFFBEEF, 1'b0);

        bus.ex_to_mem_bus = mk_ex(32'h110, 1'b1, LD_OP_LBU, 1'b1, 5'd9, 32'h00000003);
        tick;
        bus.data_sram_rdata = 32'h80FF1234;
        #1;
        check_out("lbu", 32'h110, 1'b1, 5'd9, 32'h00000080, 1'b0);

        // LW with read data three cycles late
        bus.ex_to_mem_bus = mk_ex(32'h114, 1'b1, LD_OP_LW, 1'b1, 5'd10, 32'h00002003);
        tick;
        bus.data_sram_rvalid = 1'b0;
        bus.stall            = S_HOLD;
        #1;
        check_stalled("lw_late1");
        tick;
        check_stalled("lw_late2");
        tick;
        check_stalled("lw_late3");
        tick;
        bus.data_sram_rdata  = 32'hCAFEF00D;
        bus.data_sram_rvalid = 1'b1;
        bus.stall            = S_RUN;
        bus.ex_to_mem_bus    = mk_ex(32'h118, 1'b0, LD_OP_LW, 1'b1, 5'd11, 32'h00000055);
        #1;
        check_out("lw_late", 32'h114, 1'b1, 5'd10, 32'hCAFEF00D, 1'b0);
        tick;
        bus.data_sram_rvalid = 1'b0;
        #1;
        check_out("after_lw", 32'h118, 1'b1, 5'd11, 32'h00000055, 1'b0);

        // MEM stopped with WB running inserts a bubble
        bus.stall         = S_BUBBLE;
        bus.ex_to_mem_bus = mk_ex(32'h200, 1'b0, LD_OP_LW, 1'b1, 5'd1, 32'h11);
        tick;
        check_out("bubble", 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);

        // Read data captured while MEM is stopped must survive rdata changes
        bus.stall         = S_RUN;
        bus.ex_to_mem_bus = mk_ex(32'h11C, 1'b1, LD_OP_LW, 1'b1, 5'd12, 32'h00004000);
        tick;
        bus.data_sram_rdata  = 32'h11112222;
        bus.data_sram_rvalid = 1'b1;
        bus.stall            = S_HOLD;
        #1;
        check_out("hold_cap", 32'h11C, 1'b1, 5'd12, 32'h11112222, 1'b0);
        tick;
        bus.data_sram_rvalid = 1'b0;
        bus.data_sram_rdata  = 32'h99998888;
        #1;
        check_out("hold_keep", 32'h11C, 1'b1, 5'd12, 32'h11112222, 1'b0);
        bus.data_sram_rvalid = 1'b1;
        bus.data_sram_rdata  = 32'h77776666;
        #1;
        check_out("hold_rvalid", 32'h11C, 1'b1, 5'd12, 32'h11112222, 1'b0);
        tick;
        bus.data_sram_rvalid = 1'b0;
        #1;
        check_out("hold_keep2", 32'h11C, 1'b1, 5'd12, 32'h11112222, 1'b0);
        bus.stall         = S_RUN;
        bus.ex_to_mem_bus = mk_ex(32'h120, 1'b0, LD_OP_LW, 1'b1, 5'd13, 32'h00000077);
        tick;
        check_out("hold_exit", 32'h120, 1'b1, 5'd13, 32'h00000077, 1'b0);

        // rvalid without a load is ignored
        bus.ex_to_mem_bus = mk_ex(32'h124, 1'b0, LD_OP_LB, 1'b1, 5'd14, 32'h00001234);
        tick;
        bus.data_sram_rvalid = 1'b1;
        bus.data_sram_rdata  = 32'hFFFFFFFF;
        #1;
        check_out("rv_noload", 32'h124, 1'b1, 5'd14, 32'h00001234, 1'b0);

        // Unused ld_op encoding behaves as LW; load after HOLD exit sees fresh data
        bus.ex_to_mem_bus = mk_ex(32'h128, 1'b1, 3'b111, 1'b1, 5'd15, 32'h00000003);
        tick;
        bus.data_sram_rdata = 32'hA5A55A5A;
        #1;
        check_out("op_other", 32'h128, 1'b1, 5'd15, 32'hA5A55A5A, 1'b0);

        // Reset in the middle of a wait
        bus.ex_to_mem_bus = mk_ex(32'h12C, 1'b1, LD_OP_LW, 1'b1, 5'd16, 32'h00000008);
        tick;
        bus.data_sram_rvalid = 1'b0;
        bus.stall            = S_HOLD;
        #1;
        check_stalled("wait_pre");
        tick;
        rst = 1'b0;
        #1;
        check_out("rst_mid", 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        tick;
        rst       = 1'b1;
        bus.stall = S_RUN;
        tick;
        bus.data_sram_rdata  = 32'h0BADCAFE;
        bus.data_sram_rvalid = 1'b1;
        #1;
        check_out("post_rst", 32'h12C, 1'b1, 5'd16, 32'h0BADCAFE, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
